// File: rtl/pwm_decoder_if.sv
// Signal bundle between a PWM source and pwm_decoder: the sampled waveform
// plus the recovered duty word, its valid strobe and the lock/error status.
interface pwm_decoder_if #(
  parameter int WIDTH = 8
);
  logic             PWMin;
  logic [WIDTH-1:0] Dout;
  logic             Dvalid;
  logic             Lock;
  logic             Err;

  modport master (
    output PWMin,
    input  Dout, Dvalid, Lock, Err
  );

  modport slave (
    input  PWMin,
    output Dout, Dvalid, Lock, Err
  );
endinterface

// File: rtl/pwm_decoder.sv
// PWM receiver: recovers the duty word of a fixed 2**WIDTH-clock PWM waveform.
// Define PWM_GLITCH_FILTER_EN to add a 3-sample majority filter on the input.
module pwm_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          CLK,
  input logic          aRSTin,
  pwm_decoder_if.slave bus
);

  localparam int             CW     = WIDTH + 1;
  localparam logic [CW-1:0]  PERIOD = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0]  ONE    = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, MEAS = 1'b1} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   prev_r;
  logic                   rise_s;
  logic                   at_period_s;
  logic                   timeout_s;
  logic [CW-1:0]          pcnt_r;
  logic [CW-1:0]          hcnt_r;
  state_t                 state_r, state_n;
  logic [WIDTH-1:0]       dout_r, dout_n;
  logic                   dvalid_r, dvalid_n;
  logic                   lock_r, lock_n;
  logic                   err_r, err_n;

  // input synchronizer chain
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.PWMin};
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic [1:0] hist_r;
  logic       filt_r;

  // majority vote over the last three synchronized samples rejects 1-cycle glitches
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) begin
      hist_r <= 2'b00;
      filt_r <= 1'b0;
    end else begin
      hist_r <= {hist_r[0], sync_r[SYNC_STAGES-1]};
      filt_r <= maj3(sync_r[SYNC_STAGES-1], hist_r[0], hist_r[1]);
    end
  end

  assign s_s = filt_r;
`else
  assign s_s = sync_r[SYNC_STAGES-1];
`endif

  assign rise_s      = s_s & ~prev_r;
  assign at_period_s = (pcnt_r == PERIOD);
  assign timeout_s   = at_period_s & ~rise_s;

  // edge detector delay and period/high-time counters
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) begin
      prev_r <= 1'b0;
      pcnt_r <= '0;
      hcnt_r <= '0;
    end else begin
      prev_r <= s_s;
      if (rise_s || timeout_s) begin
        pcnt_r <= ONE;
      end else if (!at_period_s) begin
        pcnt_r <= pcnt_r + ONE;
      end else begin
        pcnt_r <= pcnt_r;
      end
      if (rise_s) begin
        hcnt_r <= ONE;
      end else if (s_s && (hcnt_r != PERIOD)) begin
        hcnt_r <= hcnt_r + ONE;
      end else begin
        hcnt_r <= hcnt_r;
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) begin
      state_r  <= IDLE;
      dout_r   <= '0;
      dvalid_r <= 1'b0;
      lock_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      dout_r   <= dout_n;
      dvalid_r <= dvalid_n;
      lock_r   <= lock_n;
      err_r    <= err_n;
    end
  end

  // next-state decode; a rise landing exactly on PERIOD wins over the timeout
  always_comb begin
    state_n  = state_r;
    dout_n   = dout_r;
    dvalid_n = 1'b0;
    lock_n   = lock_r;
    err_n    = 1'b0;
    if (timeout_s) begin
      dout_n   = {WIDTH{s_s}};
      dvalid_n = 1'b1;
      lock_n   = 1'b1;
      state_n  = MEAS;
    end else if (rise_s) begin
      case (state_r)
        IDLE: begin
          state_n = MEAS;
        end
        MEAS: begin
          if (at_period_s) begin
            dout_n   = hcnt_r[WIDTH-1:0];
            dvalid_n = 1'b1;
            lock_n   = 1'b1;
            state_n  = MEAS;
          end else begin
            err_n   = 1'b1;
            lock_n  = 1'b0;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign bus.Dout   = dout_r;
  assign bus.Dvalid = dvalid_r;
  assign bus.Lock   = lock_r;
  assign bus.Err    = err_r;

endmodule
